// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared types and constants for the memory-port arbiter.
//   mem_arb_state_t : arbiter FSM states (IDLE, REQ, RESP)
//   mem_arb_owner_t : owner of the transaction in flight (NONE, FETCH, DATA)
//   MEM_SIZE_WORD   : access-size code used for instruction fetches
package mem_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RESP} mem_arb_state_t;

    typedef enum logic [1:0] {NONE, FETCH, DATA} mem_arb_owner_t;

    localparam logic [2:0] MEM_SIZE_WORD = 3'b010;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch, data and memory-side handshakes of mem_arbiter.
//   if_*  : fetch request/grant/response
//   d_*   : load/store request/grant/response
//   mem_* : single-ported memory request/grant/response
// Signal suffixes are from the arbiter's point of view.
//   modport slave  : the arbiter itself
//   modport master : the environment (core requesters plus memory)
interface mem_arbiter_if #(
    parameter int unsigned XLEN = 32
);
    logic            if_req_i;
    logic [XLEN-1:0] if_adr_i;
    logic            if_gnt_o;
    logic            if_rvalid_o;
    logic [31:0]     if_rdata_o;

    logic            d_req_i;
    logic [XLEN-1:0] d_adr_i;
    logic            d_we_i;
    logic [XLEN-1:0] d_wdata_i;
    logic [2:0]      d_size_i;
    logic            d_gnt_o;
    logic            d_rvalid_o;
    logic [XLEN-1:0] d_rdata_o;

    logic            mem_req_o;
    logic [XLEN-1:0] mem_adr_o;
    logic            mem_we_o;
    logic [XLEN-1:0] mem_wdata_o;
    logic [2:0]      mem_size_o;
    logic            mem_gnt_i;
    logic            mem_rvalid_i;
    logic [XLEN-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_adr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  d_req_i, d_adr_i, d_we_i, d_wdata_i, d_size_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output mem_req_o, mem_adr_o, mem_we_o, mem_wdata_o, mem_size_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport master (
        output if_req_i, if_adr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output d_req_i, d_adr_i, d_we_i, d_wdata_i, d_size_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  mem_req_o, mem_adr_o, mem_we_o, mem_wdata_o, mem_size_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

endinterface

// File: rtl/mem_arb_prio.sv
// mem_arb_prio: winner select for mem_arbiter, data over fetch with a starvation limit.
//   clk, reset : clock, synchronous active-high reset
//   if_req_i   : fetch request pending
//   d_req_i    : data request pending
//   arb_en_i   : arbiter can accept a request this cycle (grant takes effect)
//   if_win_o   : fetch would win
//   d_win_o    : data would win
// The streak counts consecutive data grants made while a fetch was waiting;
// once it reaches MAX_D_STREAK the next contested grant goes to fetch.
module mem_arb_prio #(
    parameter int unsigned MAX_D_STREAK = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic if_req_i,
    input  logic d_req_i,
    input  logic arb_en_i,
    output logic if_win_o,
    output logic d_win_o
);

    localparam logic [3:0] MaxStreak = 4'(MAX_D_STREAK);

    logic [3:0] streak_q, streak_d;
    logic       at_limit;

    assign at_limit = (streak_q == MaxStreak);
    assign d_win_o  = d_req_i && !(if_req_i && at_limit);
    assign if_win_o = if_req_i && !d_win_o;

    always_comb begin
        streak_d = streak_q;
        if (arb_en_i) begin
            if (d_win_o) begin
                // Only a data grant that leaves fetch waiting extends the streak.
                if (if_req_i) begin
                    streak_d = at_limit ? MaxStreak : streak_q + 4'd1;
                end else begin
                    streak_d = 4'd0;
                end
            end else if (if_win_o) begin
                streak_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            streak_q <= 4'd0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between the fetch and load/store paths.
//   clk, reset : clock, synchronous active-high reset
//   bus        : mem_arbiter_if.slave carrying fetch, data and memory handshakes
//   if_stall_cnt_o, d_stall_cnt_o : cycles each requester waited ungranted
//                                   (present only with MEM_ARB_PERF_CNT_EN defined)
// One transaction is in flight at a time: grant (IDLE or final RESP cycle) -> REQ
// until mem_gnt_i -> RESP until mem_rvalid_i. The response cycle re-arbitrates so
// back-to-back transactions have no bubble.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned MAX_D_STREAK = 4
) (
    input logic         clk,
    input logic         reset,
    mem_arbiter_if.slave bus
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0] if_stall_cnt_o,
    output logic [31:0] d_stall_cnt_o
`endif
);

    mem_arb_state_t  state_q, state_d;
    mem_arb_owner_t  owner_q, owner_d;
    logic [XLEN-1:0] adr_q, adr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            we_q, we_d;
    logic [2:0]      size_q, size_d;

    logic resp_fire;
    logic arb_en;
    logic if_win, d_win;

    // Inputs are ignored while reset is high so every output stays 0.
    assign resp_fire = !reset && (state_q == RESP) && bus.mem_rvalid_i;
    assign arb_en    = !reset && ((state_q == IDLE) || resp_fire);

    mem_arb_prio #(
        .MAX_D_STREAK(MAX_D_STREAK)
    ) u_prio (
        .clk     (clk),
        .reset   (reset),
        .if_req_i(bus.if_req_i),
        .d_req_i (bus.d_req_i),
        .arb_en_i(arb_en),
        .if_win_o(if_win),
        .d_win_o (d_win)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        size_d  = size_q;

        bus.if_gnt_o = arb_en && if_win;
        bus.d_gnt_o  = arb_en && d_win;

        unique case (state_q)
            IDLE: ;
            REQ: begin
                if (bus.mem_gnt_i) state_d = RESP;
            end
            RESP: begin
                if (bus.mem_rvalid_i) begin
                    state_d = IDLE;
                    owner_d = NONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A grant overrides the completion path above.
        if (bus.d_gnt_o) begin
            state_d = REQ;
            owner_d = DATA;
            adr_d   = bus.d_adr_i;
            wdata_d = bus.d_wdata_i;
            we_d    = bus.d_we_i;
            size_d  = bus.d_size_i;
        end else if (bus.if_gnt_o) begin
            state_d = REQ;
            owner_d = FETCH;
            adr_d   = bus.if_adr_i;
            wdata_d = '0;
            we_d    = 1'b0;
            size_d  = MEM_SIZE_WORD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= NONE;
            adr_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            size_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            size_q  <= size_d;
        end
    end

    assign bus.mem_req_o   = (state_q == REQ);
    assign bus.mem_adr_o   = adr_q;
    assign bus.mem_we_o    = we_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.mem_size_o  = size_q;

    assign bus.if_rvalid_o = resp_fire && (owner_q == FETCH);
    assign bus.d_rvalid_o  = resp_fire && (owner_q == DATA);
    assign bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i[31:0] : 32'd0;
    assign bus.d_rdata_o   = bus.d_rvalid_o ? bus.mem_rdata_i : '0;

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] if_stall_q, d_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            if_stall_q <= 32'd0;
            d_stall_q  <= 32'd0;
        end else begin
            if (bus.if_req_i && !bus.if_gnt_o) if_stall_q <= if_stall_q + 32'd1;
            if (bus.d_req_i && !bus.d_gnt_o)   d_stall_q  <= d_stall_q + 32'd1;
        end
    end

    assign if_stall_cnt_o = if_stall_q;
    assign d_stall_cnt_o  = d_stall_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus a randomized run checked against a
// transaction-level model of the arbiter (one transaction in flight, priority rule
// with a data-streak limit).
module tb_mem_arbiter;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned MAX_D = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_fail = 0;

    mem_arbiter_if #(.XLEN(XLEN)) bus ();

`ifdef MEM_ARB_PERF_CNT_EN
    logic [31:0] if_stall_cnt, d_stall_cnt;
`endif

    mem_arbiter #(
        .XLEN        (XLEN),
        .MAX_D_STREAK(MAX_D)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef MEM_ARB_PERF_CNT_EN
        ,
        .if_stall_cnt_o(if_stall_cnt),
        .d_stall_cnt_o (d_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.if_req_i     = 1'b0;
        bus.if_adr_i     = '0;
        bus.d_req_i      = 1'b0;
        bus.d_adr_i      = '0;
        bus.d_we_i       = 1'b0;
        bus.d_wdata_i    = '0;
        bus.d_size_i     = 3'b000;
        bus.mem_gnt_i    = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        bus.mem_rdata_i  = '0;
    endtask

    // Lets any in-flight transaction complete with no new requests.
    task automatic drain();
        bus.if_req_i     = 1'b0;
        bus.d_req_i      = 1'b0;
        bus.mem_gnt_i    = 1'b1;
        bus.mem_rvalid_i = 1'b1;
        repeat (3) step();
        clear_inputs();
    endtask

    task automatic test_reset();
        logic [136:0] outs;
        reset = 1'b1;
        bus.if_req_i = 1'b1; bus.d_req_i = 1'b1; bus.mem_gnt_i = 1'b1;
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hFFFF_FFFF;
        step();
        @(negedge clk);
        outs = {bus.if_gnt_o, bus.d_gnt_o, bus.if_rvalid_o, bus.d_rvalid_o, bus.if_rdata_o,
                bus.d_rdata_o, bus.mem_req_o, bus.mem_adr_o, bus.mem_we_o, bus.mem_wdata_o,
                bus.mem_size_o};
        n_cmp++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got %h want 0", outs);
        end
        step();
        reset = 1'b0;
        clear_inputs();
        step();
    endtask

    task automatic test_fetch_only();
        bus.if_req_i = 1'b1; bus.if_adr_i = 32'h8000_0000; bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.if_gnt_o, bus.d_gnt_o, bus.mem_req_o} !== 3'b100) begin
            n_fail++; $display("FAIL fetch_grant: got %b want 100",
                               {bus.if_gnt_o, bus.d_gnt_o, bus.mem_req_o});
        end
        step();
        bus.if_req_i = 1'b0; bus.if_adr_i = 32'h1234_5678;
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_req_o, bus.mem_adr_o, bus.mem_we_o, bus.mem_size_o, bus.mem_wdata_o}
            !== {1'b1, 32'h8000_0000, 1'b0, 3'b010, 32'd0}) begin
            n_fail++; $display("FAIL fetch_memreq: got req=%b adr=%h we=%b size=%b want 1 80000000 0 010",
                               bus.mem_req_o, bus.mem_adr_o, bus.mem_we_o, bus.mem_size_o);
        end
        step();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0000_0013;
        @(negedge clk);
        n_cmp++;
        if ({bus.if_rvalid_o, bus.if_rdata_o, bus.d_rvalid_o, bus.d_rdata_o, bus.mem_req_o}
            !== {1'b1, 32'h13, 1'b0, 32'd0, 1'b0}) begin
            n_fail++; $display("FAIL fetch_resp: got rv=%b data=%h drv=%b memreq=%b want 1 13 0 0",
                               bus.if_rvalid_o, bus.if_rdata_o, bus.d_rvalid_o, bus.mem_req_o);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_simultaneous();
        bus.if_req_i = 1'b1; bus.if_adr_i = 32'h100;
        bus.d_req_i = 1'b1; bus.d_adr_i = 32'h200; bus.d_we_i = 1'b1;
        bus.d_wdata_i = 32'hDEAD_BEEF; bus.d_size_i = 3'b010;
        @(negedge clk);
        n_cmp++;
        if ({bus.d_gnt_o, bus.if_gnt_o} !== 2'b10) begin
            n_fail++; $display("FAIL simul_first: got d=%b if=%b want 1 0", bus.d_gnt_o, bus.if_gnt_o);
        end
        step();
        bus.d_req_i = 1'b0; bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_req_o, bus.mem_we_o, bus.mem_adr_o, bus.mem_wdata_o, bus.if_gnt_o}
            !== {1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 1'b0}) begin
            n_fail++; $display("FAIL simul_store: got req=%b we=%b adr=%h wdata=%h want 1 1 200 deadbeef",
                               bus.mem_req_o, bus.mem_we_o, bus.mem_adr_o, bus.mem_wdata_o);
        end
        step();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h0;
        @(negedge clk);
        n_cmp++;
        if ({bus.d_rvalid_o, bus.if_rvalid_o, bus.if_gnt_o, bus.d_gnt_o} !== 4'b1010) begin
            n_fail++; $display("FAIL simul_ack_fetch_gnt: got %b want 1010",
                               {bus.d_rvalid_o, bus.if_rvalid_o, bus.if_gnt_o, bus.d_gnt_o});
        end
        step();
        bus.if_req_i = 1'b0; bus.mem_rvalid_i = 1'b0; bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_req_o, bus.mem_adr_o, bus.mem_we_o, bus.mem_wdata_o}
            !== {1'b1, 32'h100, 1'b0, 32'd0}) begin
            n_fail++; $display("FAIL simul_fetch_req: got req=%b adr=%h we=%b want 1 100 0",
                               bus.mem_req_o, bus.mem_adr_o, bus.mem_we_o);
        end
        step();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hCAFE_F00D;
        @(negedge clk);
        n_cmp++;
        if ({bus.if_rvalid_o, bus.if_rdata_o, bus.d_rvalid_o} !== {1'b1, 32'hCAFE_F00D, 1'b0}) begin
            n_fail++; $display("FAIL simul_fetch_resp: got rv=%b data=%h want 1 cafef00d",
                               bus.if_rvalid_o, bus.if_rdata_o);
        end
        step();
        clear_inputs();
    endtask

    task automatic test_starvation();
        string seq = "";
        int    grants = 0;
        bus.if_req_i = 1'b1; bus.if_adr_i = 32'h4000;
        bus.d_req_i = 1'b1; bus.d_adr_i = 32'h5000; bus.d_size_i = 3'b010;
        bus.mem_gnt_i = 1'b1; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h77;
        for (int c = 0; c < 40 && grants < 10; c++) begin
            @(negedge clk);
            if (bus.d_gnt_o) begin seq = {seq, "D"}; grants++; end
            if (bus.if_gnt_o) begin seq = {seq, "F"}; grants++; end
            step();
        end
        n_cmp++;
        if (seq != "DDDDFDDDDF") begin
            n_fail++; $display("FAIL starvation_seq: got %s want DDDDFDDDDF", seq);
        end
        drain();
    endtask

    task automatic test_backpressure();
        bus.d_req_i = 1'b1; bus.d_adr_i = 32'h300; bus.d_we_i = 1'b0; bus.d_size_i = 3'b000;
        @(negedge clk);
        n_cmp++;
        if (bus.d_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_grant: got %b want 1", bus.d_gnt_o);
        end
        step();
        bus.d_req_i = 1'b0; bus.d_adr_i = 32'hFFFF; bus.if_req_i = 1'b1; bus.if_adr_i = 32'h400;
        bus.mem_gnt_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({bus.mem_req_o, bus.mem_adr_o, bus.if_gnt_o, bus.d_gnt_o}
                !== {1'b1, 32'h300, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL bp_hold%0d: got req=%b adr=%h ifg=%b dg=%b want 1 300 0 0", c,
                                   bus.mem_req_o, bus.mem_adr_o, bus.if_gnt_o, bus.d_gnt_o);
            end
            step();
        end
        bus.mem_gnt_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_req_o, bus.if_gnt_o} !== 2'b10) begin
            n_fail++; $display("FAIL bp_accept: got %b want 10", {bus.mem_req_o, bus.if_gnt_o});
        end
        step();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'hA5A5_5A5A;
        @(negedge clk);
        n_cmp++;
        if ({bus.d_rvalid_o, bus.d_rdata_o, bus.if_gnt_o, bus.if_rvalid_o, bus.if_rdata_o}
            !== {1'b1, 32'hA5A5_5A5A, 1'b1, 1'b0, 32'd0}) begin
            n_fail++; $display("FAIL bp_resp: got drv=%b data=%h ifg=%b ifrv=%b want 1 a5a55a5a 1 0",
                               bus.d_rvalid_o, bus.d_rdata_o, bus.if_gnt_o, bus.if_rvalid_o);
        end
        step();
        drain();
    endtask

    task automatic test_reset_mid();
        logic [136:0] outs;
        bus.d_req_i = 1'b1; bus.d_adr_i = 32'h500;
        @(negedge clk);
        step();
        bus.d_req_i = 1'b0; bus.mem_gnt_i = 1'b1;
        step();
        bus.mem_gnt_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({bus.mem_req_o, bus.d_rvalid_o} !== 2'b00) begin
            n_fail++; $display("FAIL rmid_in_resp: got %b want 00", {bus.mem_req_o, bus.d_rvalid_o});
        end
        step();
        reset = 1'b1; bus.mem_rvalid_i = 1'b1; bus.if_req_i = 1'b1; bus.d_req_i = 1'b1;
        step();
        @(negedge clk);
        outs = {bus.if_gnt_o, bus.d_gnt_o, bus.if_rvalid_o, bus.d_rvalid_o, bus.if_rdata_o,
                bus.d_rdata_o, bus.mem_req_o, bus.mem_adr_o, bus.mem_we_o, bus.mem_wdata_o,
                bus.mem_size_o};
        n_cmp++;
        if (outs !== '0) begin
            n_fail++; $display("FAIL rmid_outputs: got %h want 0", outs);
        end
        step();
        reset = 1'b0; bus.if_req_i = 1'b0; bus.d_req_i = 1'b0; bus.mem_rvalid_i = 1'b0;
        step();
        bus.mem_rvalid_i = 1'b1; bus.mem_rdata_i = 32'h1111_2222;
        @(negedge clk);
        n_cmp++;
        if ({bus.if_rvalid_o, bus.d_rvalid_o, bus.mem_req_o, bus.d_rdata_o} !== {3'b000, 32'd0}) begin
            n_fail++; $display("FAIL rmid_late_rvalid: got ifrv=%b drv=%b req=%b want 0 0 0",
                               bus.if_rvalid_o, bus.d_rvalid_o, bus.mem_req_o);
        end
        step();
        bus.mem_rvalid_i = 1'b0; bus.d_req_i = 1'b1; bus.d_adr_i = 32'h600;
        @(negedge clk);
        n_cmp++;
        if (bus.d_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL rmid_idle: got d_gnt=%b want 1", bus.d_gnt_o);
        end
        step();
        drain();
    endtask

`ifdef MEM_ARB_PERF_CNT_EN
    task automatic test_perf_cnt();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.d_req_i = 1'b1; bus.d_adr_i = 32'h700;
        step();
        bus.d_req_i = 1'b0; bus.if_req_i = 1'b1; bus.if_adr_i = 32'h800; bus.mem_gnt_i = 1'b0;
        step();
        bus.mem_gnt_i = 1'b1;
        step();
        bus.mem_gnt_i = 1'b0; bus.mem_rvalid_i = 1'b0;
        step();
        bus.mem_rvalid_i = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.if_gnt_o !== 1'b1) begin
            n_fail++; $display("FAIL perf_grant: got %b want 1", bus.if_gnt_o);
        end
        step();
        bus.if_req_i = 1'b0; bus.mem_rvalid_i = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({if_stall_cnt, d_stall_cnt} !== {32'd3, 32'd0}) begin
            n_fail++; $display("FAIL perf_count: got if=%0d d=%0d want 3 0", if_stall_cnt, d_stall_cnt);
        end
        step();
        drain();
    endtask
`endif

    // Randomized traffic against a transaction-level model. Phase 0: nothing in
    // flight; 1: waiting for the memory to accept; 2: waiting for the response.
    task automatic test_random(input int cycles);
        int          phase = 0;
        int          streak = 0;
        bit          own_d = 1'b0;
        logic [31:0] t_adr = '0, t_wdata = '0;
        logic        t_we = 1'b0;
        logic [2:0]  t_size = '0;
        bit          if_pend = 1'b0, d_pend = 1'b0;
        logic [31:0] if_a = '0, d_a = '0, d_wd = '0;
        logic        d_w = 1'b0;
        logic [2:0]  d_sz = '0;
        bit          can_arb, e_ifg, e_dg, e_ifrv, e_drv, gen, done;
        done = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < cycles + 80 && !done; c++) begin
            gen = (c < cycles);
            if (gen && !if_pend && $urandom_range(0, 2) == 0) begin
                if_pend = 1'b1; if_a = $urandom;
            end
            if (gen && !d_pend && $urandom_range(0, 1) == 0) begin
                d_pend = 1'b1; d_a = $urandom; d_w = 1'($urandom_range(0, 1));
                d_wd = $urandom; d_sz = 3'($urandom_range(0, 7));
            end
            bus.if_req_i     = if_pend;
            bus.if_adr_i     = if_pend ? if_a : $urandom;
            bus.d_req_i      = d_pend;
            bus.d_adr_i      = d_pend ? d_a : $urandom;
            bus.d_we_i       = d_w;
            bus.d_wdata_i    = d_wd;
            bus.d_size_i     = d_sz;
            bus.mem_gnt_i    = ($urandom_range(0, 3) != 0);
            bus.mem_rvalid_i = ($urandom_range(0, 2) != 0);
            bus.mem_rdata_i  = $urandom;
            @(negedge clk);
            can_arb = (phase == 0) || (phase == 2 && bus.mem_rvalid_i);
            e_dg    = can_arb && d_pend && !(if_pend && streak == int'(MAX_D));
            e_ifg   = can_arb && if_pend && !e_dg;
            e_ifrv  = (phase == 2) && bus.mem_rvalid_i && !own_d;
            e_drv   = (phase == 2) && bus.mem_rvalid_i && own_d;
            n_cmp++;
            if ({bus.if_gnt_o, bus.d_gnt_o} !== {e_ifg, e_dg}) begin
                n_fail++; $display("FAIL rnd_gnt c%0d: got if=%b d=%b want if=%b d=%b", c,
                                   bus.if_gnt_o, bus.d_gnt_o, e_ifg, e_dg);
            end
            n_cmp++;
            if ({bus.if_rvalid_o, bus.d_rvalid_o} !== {e_ifrv, e_drv}) begin
                n_fail++; $display("FAIL rnd_rvalid c%0d: got if=%b d=%b want if=%b d=%b", c,
                                   bus.if_rvalid_o, bus.d_rvalid_o, e_ifrv, e_drv);
            end
            n_cmp++;
            if ({bus.if_rdata_o, bus.d_rdata_o} !== {(e_ifrv ? bus.mem_rdata_i : 32'd0),
                                                     (e_drv ? bus.mem_rdata_i : 32'd0)}) begin
                n_fail++; $display("FAIL rnd_rdata c%0d: got if=%h d=%h mem=%h", c,
                                   bus.if_rdata_o, bus.d_rdata_o, bus.mem_rdata_i);
            end
            n_cmp++;
            if (bus.mem_req_o !== (phase == 1)) begin
                n_fail++; $display("FAIL rnd_memreq c%0d: got %b want %b", c, bus.mem_req_o, phase == 1);
            end
            if (phase == 1) begin
                n_cmp++;
                if ({bus.mem_adr_o, bus.mem_we_o, bus.mem_wdata_o, bus.mem_size_o}
                    !== {t_adr, t_we, t_wdata, t_size}) begin
                    n_fail++; $display("FAIL rnd_memfields c%0d: got %h %b %h %b want %h %b %h %b", c,
                                       bus.mem_adr_o, bus.mem_we_o, bus.mem_wdata_o, bus.mem_size_o,
                                       t_adr, t_we, t_wdata, t_size);
                end
            end
            if (phase == 1 && bus.mem_gnt_i) phase = 2;
            else if (phase == 2 && bus.mem_rvalid_i) phase = 0;
            if (e_dg) begin
                phase = 1; own_d = 1'b1; t_adr = d_a; t_we = d_w; t_wdata = d_wd; t_size = d_sz;
                streak = if_pend ? ((streak < int'(MAX_D)) ? streak + 1 : streak) : 0;
                d_pend = 1'b0;
            end else if (e_ifg) begin
                phase = 1; own_d = 1'b0; t_adr = if_a; t_we = 1'b0; t_wdata = '0; t_size = 3'b010;
                streak = 0;
                if_pend = 1'b0;
            end
            if (!gen && phase == 0 && !if_pend && !d_pend) done = 1'b1;
            step();
        end
        n_cmp++;
        if (!done) begin
            n_fail++; $display("FAIL rnd_drain: got phase=%0d pend=%b%b want idle", phase, if_pend, d_pend);
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        step();
        step();
        test_reset();
        test_fetch_only();
        test_simultaneous();
        test_starvation();
        test_backpressure();
        test_reset_mid();
`ifdef MEM_ARB_PERF_CNT_EN
        test_perf_cnt();
`endif
        test_random(600);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one external memory port between the ifetch instruction path and the exe load/store path.
- Sits between the core's two memory interfaces (fetch address/instruction, data address/store/load) and a single-ported memory.
- Exactly one transaction in flight at a time.
- Fixed data-over-fetch priority, with an anti-starvation limit that guarantees fetch progress.

Parameters:
- XLEN, 32, address/data width.
- MAX_D_STREAK, 4, max consecutive data grants while a fetch is pending; range 1..15.

Ports:
- clk  in  1  core clock
- reset  in  1  reset; one clock; reset is synchronous and active-high (clk, reset)
- if_req_i  in  1  fetch request
- if_adr_i  in  XLEN  fetch address
- if_gnt_o  out  1  fetch request accepted (1-cycle pulse)
- if_rvalid_o  out  1  fetch data valid
- if_rdata_o  out  32  fetched instruction
- d_req_i  in  1  data request
- d_adr_i  in  XLEN  data address
- d_we_i  in  1  1=store
- d_wdata_i  in  XLEN  store data
- d_size_i  in  3  access size, same encoding as exe access_size
- d_gnt_o  out  1  data request accepted (1-cycle pulse)
- d_rvalid_o  out  1  data response valid (load data or store ack)
- d_rdata_o  out  XLEN  load data
- mem_req_o  out  1  memory request
- mem_adr_o  out  XLEN  memory address
- mem_we_o  out  1  memory write enable
- mem_wdata_o  out  XLEN  memory write data
- mem_size_o  out  3  memory access size
- mem_gnt_i  in  1  memory accepted request
- mem_rvalid_i  in  1  memory response valid (reads and writes)
- mem_rdata_i  in  XLEN  memory read data

Behaviour:
- Reset (synchronous):
  - state=IDLE, streak=0, owner=NONE.
  - All outputs are 0 from the first clk edge with reset high.
- FSM states: IDLE, REQ, RESP.
- Arbitration (combinational; evaluated in IDLE, and in RESP in the cycle mem_rvalid_i=1):
  - Winner = data if d_req_i and not (if_req_i and streak==MAX_D_STREAK).
  - Otherwise winner = fetch if if_req_i.
  - Otherwise no grant.
- Grant cycle:
  - Winner's gnt_o=1 combinationally.
  - Request fields are latched into owner registers (fetch: we=0, size=3'b010, wdata=0).
  - Next state is REQ.
- Requester handshake: hold req and fields stable until its gnt_o; req may drop or change in the cycle after gnt.
- REQ:
  - mem_req_o=1, mem_* driven from the latched registers and stable until mem_gnt_i.
  - On mem_gnt_i=1, next state is RESP; mem_req_o=0 from the next cycle.
- RESP:
  - mem_req_o=0.
  - On mem_rvalid_i=1, the owner's rvalid_o=1 in the same cycle, with rdata_o=mem_rdata_i (if_rdata_o takes bits [31:0]).
  - Non-owner rvalid_o stays 0.
  - The same cycle re-arbitrates: grant → REQ; else → IDLE.
- Streak counter (4-bit), updated at each grant:
  - Data grant with if_req_i=1 → streak+1, saturating at MAX_D_STREAK.
  - Data grant with if_req_i=0 → streak=0.
  - Fetch grant → streak=0.
- Latency:
  - Minimum 3 cycles from grant to response: grant, REQ with immediate mem_gnt, RESP with immediate rvalid.
  - Back-to-back: the next grant coincides with the rvalid cycle.
- Boundary conditions:
  - mem_rvalid_i in IDLE or REQ is ignored.
  - mem_gnt_i outside REQ is ignored.
  - rdata outputs are 0 when the corresponding rvalid_o=0.
  - Both requests with streak<MAX → data wins.
  - Both requests with streak==MAX → fetch wins, streak=0.
  - Reset mid-transaction: FSM returns to IDLE and the in-flight response is dropped. A late mem_rvalid_i after reset is ignored because the FSM is in IDLE.

Optional Feature:
- Macro MEM_ARB_PERF_CNT_EN.
- Defined:
  - Adds ports if_stall_cnt_o (out, 32) and d_stall_cnt_o (out, 32).
  - Each counts cycles its req_i=1 and gnt_o=0.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- riscv_pkg additions:
  - typedef enum logic[1:0] mem_arb_state_t {IDLE, REQ, RESP}.
  - typedef enum logic[1:0] mem_arb_owner_t {NONE, FETCH, DATA}.
  - localparam MEM_SIZE_WORD = 3'b010.
- One sub-module: mem_arb_prio (combinational winner select plus streak register).
- FSM and datapath latches live in mem_arbiter.

Test Plan:
- Fetch only:
  - Stimulus: if_req_i=1, if_adr_i=0x80000000; memory grants and returns 0x00000013 after 1 cycle.
  - Required response: if_gnt_o at cycle 0, mem_req_o at cycle 1 with adr 0x80000000 and we=0, if_rvalid_o at cycle 2 with 0x00000013.
- Simultaneous requests, streak 0:
  - Stimulus: fetch requests 0x100; data stores 0xDEADBEEF to 0x200 with size 3'b010.
  - Required response: d_gnt_o first, mem_we_o=1, d_rvalid_o ack; fetch granted on the d_rvalid_o cycle.
- Starvation limit, MAX_D_STREAK=4:
  - Stimulus: d_req_i and if_req_i held at 1 continuously.
  - Required response: grant sequence D,D,D,D,F,D,D,D,D,F.
- Memory backpressure:
  - Stimulus: mem_gnt_i low for 5 cycles.
  - Required response: mem_req_o and mem_adr_o stable for all 5 cycles; no second grant issued.
- Reset mid-transaction:
  - Stimulus: reset asserted in RESP, then mem_rvalid_i=1 one cycle after reset deasserts.
  - Required response: all outputs 0 during reset; no rvalid_o to either requester; FSM in IDLE.
- Perf counters (MEM_ARB_PERF_CNT_EN defined):
  - Stimulus: fetch waits 3 cycles behind data.
  - Required response: if_stall_cnt_o=3.
